// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for processor_datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects and the
// PC/IR enables. It also runs the req/ready handshake with data memory, traps
// on illegal opcodes and memory timeouts, and counts retired instructions.
// Outputs are decoded combinationally from the state register and the
// opcode/funct fields latched in DECODE, and are forced low while rst is low.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       inst_control,
  input  logic [9:0]       inst_alu,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             regw,
  output logic             sel,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             sel2,
  output logic             pc_en,
  output logic             ir_en,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [2:0]       state_o,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_I    = 3'd2,
    C_LD   = 3'd3,
    C_ST   = 3'd4,
    C_BR   = 3'd5
  } iclass_t;

  // Map a 7-bit opcode onto the instruction classes this controller sequences.
  function automatic iclass_t classify(input logic [6:0] opc);
    iclass_t cls;
    case (opc)
      OP_R:    cls = C_R;
      OP_I:    cls = C_I;
      OP_LD:   cls = C_LD;
      OP_ST:   cls = C_ST;
      OP_BR:   cls = C_BR;
      default: cls = C_NONE;
    endcase
    return cls;
  endfunction

  // Legality check done in DECODE on the live instruction fields.
  function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
    logic ok;
    case (classify(opc))
      C_R, C_I:   ok = (f3 != 3'b011);
      C_LD, C_ST: ok = 1'b1;
      C_BR:       ok = (f3 == 3'b000) || (f3 == 3'b001);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU operation for a latched instruction; funct7[5] picks SUB (R only) and SRA.
  function automatic logic [3:0] decode_alu_op(input iclass_t cls, input logic [2:0] f3,
                                               input logic f7b5);
    logic [3:0] op;
    op = ALU_ADD;
    case (cls)
      C_LD, C_ST: op = ALU_ADD;
      C_BR:       op = ALU_SUB;
      C_R, C_I: begin
        case (f3)
          3'b000:  op = (cls == C_R && f7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          3'b100:  op = ALU_XOR;
          3'b001:  op = ALU_SLL;
          3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
          3'b010:  op = ALU_SLT;
          default: op = ALU_ADD;
        endcase
      end
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

  state_t             r_state;
  state_t             w_next;
  logic [6:0]         r_opc;
  logic [9:0]         r_alu;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_instret;

  iclass_t            w_cls;
  logic [2:0]         w_f3;
  logic               w_f7b5;
  logic [3:0]         w_alu_op_dec;
  logic               w_imm;
  logic               w_taken;
  logic               w_unused_alu;

  logic               w_regw;
  logic               w_sel;
  logic               w_alu_src;
  logic [3:0]         w_alu_op;
  logic               w_sel2;
  logic               w_pc_en;
  logic               w_ir_en;
  logic               w_mem_rd;
  logic               w_mem_wr;
  logic               w_fault;

  assign w_cls        = classify(r_opc);
  assign w_f3         = r_alu[2:0];
  assign w_f7b5       = r_alu[8];
  assign w_alu_op_dec = decode_alu_op(w_cls, w_f3, w_f7b5);
  assign w_imm        = (w_cls == C_I) || (w_cls == C_LD) || (w_cls == C_ST);
  assign w_taken      = ((w_f3 == 3'b000) && zero_flag) || ((w_f3 == 3'b001) && !zero_flag);
  assign w_unused_alu = ^{r_alu[9], r_alu[7:3]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture opcode and {funct7,funct3} while the IR holds the new instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opc <= 7'd0;
      r_alu <= 10'd0;
    end else if (r_state == S_DECODE) begin
      r_opc <= inst_control;
      r_alu <= inst_alu;
    end
  end

  // Memory wait counter: counts MEM cycles without ready, zero outside MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait <= '0;
    end else if (r_state != S_MEM) begin
      r_wait <= '0;
    end else if (!mem_ready) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Retired-instruction counter, one count per PC load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= '0;
    end else if (w_pc_en) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    w_next    = r_state;
    w_regw    = 1'b0;
    w_sel     = 1'b0;
    w_alu_src = 1'b0;
    w_alu_op  = 4'b0000;
    w_sel2    = 1'b0;
    w_pc_en   = 1'b0;
    w_ir_en   = 1'b0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_fault   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_en = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        w_next = is_legal(inst_control, inst_alu[2:0]) ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        w_alu_src = w_imm;
        w_alu_op  = w_alu_op_dec;
        case (w_cls)
          C_R, C_I:   w_next = S_WB;
          C_LD, C_ST: w_next = S_MEM;
          C_BR: begin
            w_pc_en = 1'b1;
            w_sel   = w_taken;
            w_next  = S_FETCH;
          end
          default:    w_next = S_FAULT;
        endcase
      end
      S_MEM: begin
        w_alu_src = w_imm;
        w_alu_op  = w_alu_op_dec;
        w_mem_rd  = (w_cls == C_LD);
        w_mem_wr  = (w_cls == C_ST);
        if ((w_cls != C_LD) && (w_cls != C_ST)) begin
          w_next = S_FAULT;
        end else if (mem_ready) begin
          if (w_cls == C_ST) begin
            w_pc_en = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next  = S_WB;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        w_alu_src = w_imm;
        w_alu_op  = w_alu_op_dec;
        w_regw    = 1'b1;
        w_pc_en   = 1'b1;
        w_sel2    = (w_cls == C_LD);
        w_next    = S_FETCH;
      end
      S_FAULT: begin
        w_fault = 1'b1;
        w_next  = S_FAULT;
      end
      default: begin
        w_next = S_FAULT;
      end
    endcase
  end

  // Drive ports; everything reads zero while rst is held low.
  always_comb begin
    regw    = rst & w_regw;
    sel     = rst & w_sel;
    alu_src = rst & w_alu_src;
    alu_op  = rst ? w_alu_op : 4'b0000;
    sel2    = rst & w_sel2;
    pc_en   = rst & w_pc_en;
    ir_en   = rst & w_ir_en;
    mem_rd  = rst & w_mem_rd;
    mem_wr  = rst & w_mem_wr;
    fault   = rst & w_fault;
    state_o = r_state;
    instret = r_instret;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench for multicycle_controller: each driven cycle pushes the
// expected output vector, and a negedge monitor pops and compares it.
module tb_multicycle_controller;

  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int unsigned CNT_W       = 32;

  logic             clk;
  logic             rst;
  logic [6:0]       inst_control;
  logic [9:0]       inst_alu;
  logic             zero_flag;
  logic             mem_ready;
  logic             regw;
  logic             sel;
  logic             alu_src;
  logic [3:0]       alu_op;
  logic             sel2;
  logic             pc_en;
  logic             ir_en;
  logic             mem_rd;
  logic             mem_wr;
  logic [2:0]       state_o;
  logic             fault;
  logic [CNT_W-1:0] instret;

  multicycle_controller #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_control (inst_control),
    .inst_alu     (inst_alu),
    .zero_flag    (zero_flag),
    .mem_ready    (mem_ready),
    .regw         (regw),
    .sel          (sel),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .sel2         (sel2),
    .pc_en        (pc_en),
    .ir_en        (ir_en),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .state_o      (state_o),
    .fault        (fault),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [47:0] v;
  } sb_t;

  sb_t         sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret = 32'd0;

  task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {instret, state, fault, ir_en, regw, pc_en, sel, sel2, alu_src, alu_op, mem_rd, mem_wr}
  function automatic logic [47:0] obs_vec();
    return {instret, state_o, fault, ir_en, regw, pc_en, sel, sel2, alu_src, alu_op, mem_rd, mem_wr};
  endfunction

  always @(negedge clk) begin : monitor
    sb_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs_vec(), e.v);
    end
  end

  // Push the expectation for the current cycle, then move to the next cycle.
  task automatic exp_cycle(input string tag, input logic [2:0] st, input logic flt, input logic ir,
                           input logic rw, input logic pc, input logic sl, input logic s2,
                           input logic as, input logic [3:0] op, input logic rd, input logic wr);
    sb_t e;
    e.tag = tag;
    e.v   = {exp_instret, st, flt, ir, rw, pc, sl, s2, as, op, rd, wr};
    sb.push_back(e);
    if (pc) exp_instret++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_side();
    zero_flag = 1'($urandom);
    mem_ready = 1'($urandom);
  endtask

  task automatic reset_dut(input string tag);
    rst = 1'b0;
    #1;
    check_eq({tag, ".async"}, obs_vec(), 48'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq({tag, ".hold"}, obs_vec(), 48'd0);
    rst = 1'b1;
    exp_instret = 32'd0;
  endtask

  // Legal instruction: full sequence with bench-given ALU expectations.
  task automatic run_instr(input string nm, input logic [31:0] inst, input logic z,
                           input int waits, input logic [3:0] op, input logic as);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       is_br;
    logic       is_ld;
    logic       is_st;
    logic       taken;
    opc   = inst[6:0];
    f3    = inst[14:12];
    is_br = (opc == 7'b1100011);
    is_ld = (opc == 7'b0000011);
    is_st = (opc == 7'b0100011);
    inst_control = opc;
    inst_alu     = {inst[31:25], inst[14:12]};
    rand_side();
    exp_cycle({nm, ".F"}, 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    rand_side();
    exp_cycle({nm, ".D"}, 3'd1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    inst_control = 7'($urandom);
    inst_alu     = 10'($urandom);
    zero_flag    = z;
    mem_ready    = 1'($urandom);
    if (is_br) begin
      taken = (f3 == 3'b000) ? z : !z;
      exp_cycle({nm, ".E"}, 3'd2, 0, 0, 0, 1, taken, 0, as, op, 0, 0);
    end else begin
      exp_cycle({nm, ".E"}, 3'd2, 0, 0, 0, 0, 0, 0, as, op, 0, 0);
    end
    if (is_ld || is_st) begin
      for (int i = 0; i < waits; i++) begin
        zero_flag = 1'($urandom);
        mem_ready = 1'b0;
        exp_cycle({nm, ".Mw"}, 3'd3, 0, 0, 0, 0, 0, 0, as, op, is_ld, is_st);
      end
      mem_ready = 1'b1;
      exp_cycle({nm, ".Mr"}, 3'd3, 0, 0, 0, is_st, 0, 0, as, op, is_ld, is_st);
    end
    if (!is_br && !is_st) begin
      rand_side();
      exp_cycle({nm, ".W"}, 3'd4, 0, 0, 1, 1, 0, is_ld, as, op, 0, 0);
    end
  endtask

  // Instruction rejected in DECODE: FAULT held with all enables low.
  task automatic run_illegal(input string nm, input logic [6:0] opc, input logic [9:0] alu,
                             input int ncyc);
    inst_control = opc;
    inst_alu     = alu;
    rand_side();
    exp_cycle({nm, ".F"}, 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    rand_side();
    exp_cycle({nm, ".D"}, 3'd1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    for (int i = 0; i < ncyc; i++) begin
      inst_control = 7'($urandom);
      inst_alu     = 10'($urandom);
      rand_side();
      exp_cycle({nm, ".X"}, 3'd7, 1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    end
  endtask

  // Store whose memory never answers.
  task automatic run_st_timeout(input string nm);
    inst_control = 7'b0100011;
    inst_alu     = 10'b0000000_010;
    rand_side();
    exp_cycle({nm, ".F"}, 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    rand_side();
    exp_cycle({nm, ".D"}, 3'd1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    rand_side();
    exp_cycle({nm, ".E"}, 3'd2, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 0, 0);
    for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
      zero_flag = 1'($urandom);
      mem_ready = 1'b0;
      exp_cycle({nm, ".Mw"}, 3'd3, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 0, 1);
    end
    for (int i = 0; i < 6; i++) begin
      rand_side();
      exp_cycle({nm, ".X"}, 3'd7, 1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    end
  endtask

  // Load aborted by reset in its second MEM cycle.
  task automatic run_ld_reset(input string nm);
    inst_control = 7'b0000011;
    inst_alu     = 10'b0000000_010;
    rand_side();
    exp_cycle({nm, ".F"}, 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    rand_side();
    exp_cycle({nm, ".D"}, 3'd1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    rand_side();
    exp_cycle({nm, ".E"}, 3'd2, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 0, 0);
    mem_ready = 1'b0;
    exp_cycle({nm, ".M1"}, 3'd3, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 1, 0);
    mem_ready = 1'b0;
    #1;
    check_eq({nm, ".M2"}, obs_vec(), {exp_instret, 3'd3, 7'b0000001, 4'b0010, 2'b10});
    mem_ready = 1'b1;
    reset_dut({nm, ".rst"});
  endtask

  initial begin
    rst          = 1'b1;
    inst_control = 7'd0;
    inst_alu     = 10'd0;
    zero_flag    = 1'b0;
    mem_ready    = 1'b0;
    #1;
    reset_dut("por");

    run_instr("ADD",   32'h00B50533, 0, 0, 4'b0010, 0);
    run_instr("SUB",   32'h40B50533, 0, 0, 4'b0110, 0);
    run_instr("ADDI",  32'h00150513, 0, 0, 4'b0010, 1);
    run_instr("ADDIb", 32'h40050513, 0, 0, 4'b0010, 1);
    run_instr("AND",   32'h00B57533, 0, 0, 4'b0000, 0);
    run_instr("OR",    32'h00B56533, 0, 0, 4'b0001, 0);
    run_instr("XOR",   32'h00B54533, 0, 0, 4'b0011, 0);
    run_instr("SLL",   32'h00B51533, 0, 0, 4'b0100, 0);
    run_instr("SRL",   32'h00B55533, 0, 0, 4'b0101, 0);
    run_instr("SRA",   32'h40B55533, 0, 0, 4'b0111, 0);
    run_instr("SRAI",  32'h40355513, 0, 0, 4'b0111, 1);
    run_instr("SLT",   32'h00B52533, 0, 0, 4'b1000, 0);
    run_instr("SLTI",  32'h00552513, 0, 0, 4'b1000, 1);
    run_instr("LW3",   32'h00052503, 0, 3, 4'b0010, 1);
    run_instr("LW0",   32'h00052503, 0, 0, 4'b0010, 1);
    run_instr("LWmax", 32'h00052503, 0, int'(MEM_TIMEOUT) - 1, 4'b0010, 1);
    run_instr("SW0",   32'h00A52023, 0, 0, 4'b0010, 1);
    run_instr("SW2",   32'h00A52023, 0, 2, 4'b0010, 1);
    run_instr("BEQz1", 32'h00000063, 1, 0, 4'b0110, 0);
    run_instr("BEQz0", 32'h00000063, 0, 0, 4'b0110, 0);
    run_instr("BNEz1", 32'h00001063, 1, 0, 4'b0110, 0);
    run_instr("BNEz0", 32'h00001063, 0, 0, 4'b0110, 0);

    run_ld_reset("LWrst");
    run_instr("ADDr",  32'h00B50533, 0, 0, 4'b0010, 0);

    run_illegal("ILL7F", 7'h7F, 10'($urandom), 20);
    reset_dut("rst1");
    run_illegal("SLTU", 7'b0110011, 10'b0000000_011, 5);
    reset_dut("rst2");
    run_illegal("BRf2", 7'b1100011, 10'b0000000_010, 5);
    reset_dut("rst3");
    run_illegal("SLTIU", 7'b0010011, 10'b0000000_011, 5);
    reset_dut("rst4");
    run_st_timeout("SWto");
    reset_dut("rst5");
    run_instr("ADDf",  32'h00B50533, 0, 0, 4'b0010, 0);

    @(negedge clk);
    #1;
    check_eq("sb_empty", 48'(sb.size()), 48'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
